// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// func3 codes, the M-extension funct7 and the 2-bit FSM encoding.
package ex_muldiv_pkg;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } md_state_e;

    function automatic logic op1_signed(input logic [2:0] f3);
        return (f3 == INST_MULH) || (f3 == INST_MULHSU) ||
               (f3 == INST_DIV)  || (f3 == INST_REM);
    endfunction

    function automatic logic op2_signed(input logic [2:0] f3);
        return (f3 == INST_MULH) || (f3 == INST_DIV) || (f3 == INST_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One combinational radix-2 step: shift-add for multiply,
// restoring trial-subtract for divide, on magnitudes only.
module md_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] m_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] part;
    logic [XLEN:0] diff;

    always_comb begin
        sum  = {1'b0, hi_i} + {1'b0, (lo_i[0] ? m_i : '0)};
        part = {hi_i, lo_i[XLEN-1]};
        diff = part - {1'b0, m_i};
        if (is_div) begin
            // borrow out of the trial subtract means the divisor did not fit
            hi_o = diff[XLEN] ? part[XLEN-1:0] : diff[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], ~diff[XLEN]};
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M execute unit: holds the pipeline while it computes,
// then pulses valid/reg_wen for one cycle with the rd result.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o,
    output logic            reg_wen_o
);

    localparam int ITER = XLEN / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER + 1);

    md_state_e state, state_nx;

    logic [CW-1:0]   cnt;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q, rd_out_q;
    logic            neg_q, spec_q;
    logic [XLEN-1:0] hi_q, lo_q, m_q, spec_val_q, res_q;

    logic            s1, s2, neg_i, is_div_i, is_rem_i;
    logic            div_zero, ovf, special, accept;
    logic [XLEN-1:0] abs1, abs2, spec_val, fix;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quo, rem;

    logic [XLEN-1:0] hi_c [0:BITS_PER_CYCLE];
    logic [XLEN-1:0] lo_c [0:BITS_PER_CYCLE];

    always_comb begin
        s1       = op1_signed(func3_i) & op1_i[XLEN-1];
        s2       = op2_signed(func3_i) & op2_i[XLEN-1];
        abs1     = s1 ? -op1_i : op1_i;
        abs2     = s2 ? -op2_i : op2_i;
        is_div_i = func3_i[2];
        is_rem_i = func3_i[2] & func3_i[1];
        neg_i    = is_rem_i ? s1 : (s1 ^ s2);
        div_zero = is_div_i & (op2_i == '0);
        ovf      = ((func3_i == INST_DIV) || (func3_i == INST_REM)) &&
                   (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
        special  = div_zero | ovf;
        accept   = start_i & ~flush_i;
        if (div_zero)
            spec_val = is_rem_i ? op1_i : '1;
        else
            spec_val = is_rem_i ? '0 : op1_i;
    end

    assign hi_c[0] = hi_q;
    assign lo_c[0] = lo_q;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        md_step #(.XLEN(XLEN)) u_step (
            .is_div (f3_q[2]),
            .hi_i   (hi_c[g]),
            .lo_i   (lo_c[g]),
            .m_i    (m_q),
            .hi_o   (hi_c[g+1]),
            .lo_o   (lo_c[g+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (accept) state_nx = special ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush_i)       state_nx = S_IDLE;
                else if (cnt == 1) state_nx = S_DONE;
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        valid_o   = (state == S_DONE);
        reg_wen_o = valid_o;
        busy_o    = ((state == S_IDLE) & accept & ~special) |
                    (state == S_CALC);
        result_o  = valid_o ? fix : res_q;
        rd_addr_o = valid_o ? rd_q : rd_out_q;
    end

    // sign fix-up works on the whole 2*XLEN product so MULH* stay exact
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_q ? -prod : prod;
        quo      = neg_q ? -lo_q : lo_q;
        rem      = neg_q ? -hi_q : hi_q;
        fix      = '0;
        unique case (1'b1)
            spec_q:
                fix = spec_val_q;
            ~spec_q & (f3_q == INST_MUL):
                fix = prod_fix[XLEN-1:0];
            ~spec_q & ~f3_q[2] & (f3_q[1:0] != 2'b00):
                fix = prod_fix[2*XLEN-1:XLEN];
            ~spec_q & f3_q[2] & ~f3_q[1]:
                fix = quo;
            ~spec_q & f3_q[2] & f3_q[1]:
                fix = rem;
            default: fix = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            rd_out_q   <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            m_q        <= '0;
            spec_val_q <= '0;
            res_q      <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (accept) begin
                    f3_q       <= func3_i;
                    rd_q       <= rd_addr_i;
                    neg_q      <= neg_i;
                    spec_q     <= special;
                    spec_val_q <= spec_val;
                    hi_q       <= '0;
                    lo_q       <= abs1;
                    m_q        <= abs2;
                    cnt        <= CW'(ITER);
                end
                S_CALC: begin
                    hi_q <= hi_c[BITS_PER_CYCLE];
                    lo_q <= lo_c[BITS_PER_CYCLE];
                    cnt  <= cnt - 1'b1;
                end
                S_DONE: begin
                    res_q    <= fix;
                    rd_out_q <= rd_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed table, random ops against
// a plain-arithmetic model, plus flush and async-reset sequences.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  func3_i = '0;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;

    logic        busy1, valid1, wen1;
    logic [31:0] res1;
    logic [4:0]  rd1;
    logic        busy4, valid4, wen4;
    logic [31:0] res4;
    logic [4:0]  rd4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start_i), .func3_i(func3_i),
        .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i),
        .flush_i(flush_i), .busy_o(busy1), .valid_o(valid1),
        .result_o(res1), .rd_addr_o(rd1), .reg_wen_o(wen1)
    );

    ex_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .start_i(start_i), .func3_i(func3_i),
        .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i),
        .flush_i(flush_i), .busy_o(busy4), .valid_o(valid4),
        .result_o(res4), .rd_addr_o(rd4), .reg_wen_o(wen4)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] f,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ub = longint'({32'b0, b});
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ubv = {32'b0, b};
        logic [63:0] p;
        logic ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ubv; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ov) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ov) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        return f[2] && ((b == 0) || ((f == 3'd4 || f == 3'd6) &&
               a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic run_op(input string name, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp);
        bit sp = is_special(f, a, b);
        int lat1 = 0, lat4 = 0;
        logic [31:0] r1 = '0, r4 = '0;
        logic [4:0] rdo = '0;
        logic wen = 1'b0;
        bit busy_ok = 1'b1, pulse_ok = 1'b1;
        @(negedge clk);
        func3_i = f; op1_i = a; op2_i = b; rd_addr_i = rd; start_i = 1'b1;
        #1;
        if (busy1 !== !sp) busy_ok = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (lat1 == 0 && valid1) begin
                lat1 = c; r1 = res1; rdo = rd1; wen = wen1;
                if (busy1 !== 1'b0) busy_ok = 1'b0;
            end else if (lat1 == 0 && busy1 !== 1'b1 && !sp) begin
                busy_ok = 1'b0;
            end else if (lat1 != 0 && valid1) begin
                pulse_ok = 1'b0;
            end
            if (lat4 == 0 && valid4) begin
                lat4 = c; r4 = res4;
            end
        end
        chk({name, " result"}, r1, exp);
        chk({name, " result_bpc4"}, r4, exp);
        chk({name, " latency"}, lat1, sp ? 1 : 33);
        chk({name, " latency_bpc4"}, lat4, sp ? 1 : 9);
        chk({name, " rd_addr"}, {27'b0, rdo}, {27'b0, rd});
        chk({name, " reg_wen"}, {31'b0, wen}, 32'd1);
        chk({name, " busy"}, {31'b0, busy_ok}, 32'd1);
        chk({name, " pulse"}, {31'b0, pulse_ok}, 32'd1);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        bit saw;
        tbl[0]  = '{"mul_7x-3",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB};
        tbl[1]  = '{"mulh_min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        tbl[2]  = '{"mulhu_max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[3]  = '{"mulhsu_m1",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[4]  = '{"div_-7_2",    3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD};
        tbl[5]  = '{"rem_-7_2",    3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF};
        tbl[6]  = '{"divu_100_7",  3'd5, 32'd100,      32'd7,        32'd14};
        tbl[7]  = '{"remu_100_7",  3'd7, 32'd100,      32'd7,        32'd2};
        tbl[8]  = '{"divu_5_0",    3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF};
        tbl[9]  = '{"rem_5_0",     3'd6, 32'd5,        32'd0,        32'd5};
        tbl[10] = '{"div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[11] = '{"rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        tbl[12] = '{"mul_12x12",   3'd0, 32'd12,       32'd12,       32'd144};

        #1;
        chk("reset busy", {31'b0, busy1}, 32'd0);
        chk("reset valid", {31'b0, valid1}, 32'd0);
        chk("reset result", res1, 32'd0);
        chk("reset rd", {27'b0, rd1}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++)
            run_op(tbl[i].name, tbl[i].f, tbl[i].a, tbl[i].b,
                   5'(i + 1), tbl[i].exp);

        run_op("mul_rd0", 3'd0, 32'd5, 32'd6, 5'd0, 32'd30);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] f = 3'($urandom_range(0, 7));
            logic [31:0] a = $urandom;
            logic [31:0] b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = 32'($urandom_range(1, 9));
                2: a = 32'($urandom_range(0, 300));
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run_op($sformatf("rand%0d_f%0d", i, f), f, a, b,
                   5'($urandom_range(0, 31)), ref_md(f, a, b));
        end

        // abort in CALC cycle 10
        @(negedge clk);
        func3_i = 3'd5; op1_i = 32'd100; op2_i = 32'd7; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush busy_drop", {31'b0, busy1}, 32'd0);
        saw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (valid1) saw = 1'b1;
        end
        chk("flush no_valid", {31'b0, saw}, 32'd0);
        run_op("divu_9_3_after_flush", 3'd5, 32'd9, 32'd3, 5'd7, 32'd3);

        // flush together with start is not accepted
        @(negedge clk);
        func3_i = 3'd0; op1_i = 32'd3; op2_i = 32'd3;
        start_i = 1'b1; flush_i = 1'b1;
        #1;
        chk("flush_start busy", {31'b0, busy1}, 32'd0);
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        chk("flush_start busy_after", {31'b0, busy1}, 32'd0);
        saw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (valid1 || valid4) saw = 1'b1;
        end
        chk("flush_start no_valid", {31'b0, saw}, 32'd0);

        // async reset between edges in the middle of CALC
        @(negedge clk);
        func3_i = 3'd0; op1_i = 32'd9; op2_i = 32'd9; rd_addr_i = 5'd4;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst busy", {31'b0, busy1}, 32'd0);
        chk("async_rst valid", {31'b0, valid1}, 32'd0);
        chk("async_rst result", res1, 32'd0);
        chk("async_rst rd", {27'b0, rd1}, 32'd0);
        chk("async_rst result_bpc4", res4, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("mul_after_rst", 3'd0, 32'd12, 32'd12, 5'd9, 32'd144);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
